sobel_frame_ctrl: RTL

Frame sequencer for the Sobel edge pipeline between the 24-bit input FIFO and the 8-bit output FIFO. It pops pixels from the input FIFO and tracks raster column and row. It tells the line-buffer and window datapath when to shift, when the 3x3 window is valid, and when a pixel is on the border. It tracks results through the datapath latency, writes them to the output FIFO with backpressure, and signals frame completion after exactly (HEIGHT-2)*WIDTH outputs.

---
 rtl/sobel_pkg.sv | 13 +
 rtl/sobel_frame_ctrl_if.sv | 31 +++
 rtl/sobel_valid_pipe.sv | 29 ++
 rtl/sobel_frame_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and default geometry for the Sobel frame controller.
package sobel_pkg;
    localparam int IMG_WIDTH      = 720;
    localparam int IMG_HEIGHT     = 720;
    localparam int SOBEL_PIPE_LAT = 4;

    typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} ctrl_state_t;

    typedef struct packed {
        logic emit;
        logic border;
    } trk_t;
endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// sobel_frame_ctrl_if: input FIFO pop, window datapath strobes and output FIFO push.
interface sobel_frame_ctrl_if
    import sobel_pkg::*;
#(
    parameter int COL_W = $clog2(IMG_WIDTH),
    parameter int ROW_W = $clog2(IMG_HEIGHT)
);
    logic             in_empty;
    logic             in_rd_en;
    logic             px_valid;
    logic [COL_W-1:0] px_col;
    logic [ROW_W-1:0] px_row;
    logic             win_valid;
    logic             border;
    logic             pipe_en;
    logic             out_full;
    logic             out_wr_en;
    logic             out_force_zero;

    modport master (
        input  in_empty, out_full,
        output in_rd_en, px_valid, px_col, px_row, win_valid, border, pipe_en,
               out_wr_en, out_force_zero
    );

    modport slave (
        output in_empty, out_full,
        input  in_rd_en, px_valid, px_col, px_row, win_valid, border, pipe_en,
               out_wr_en, out_force_zero
    );
endinterface

// File: rtl/sobel_valid_pipe.sv
// sobel_valid_pipe: enable-gated shift register that shadows the datapath latency.
module sobel_valid_pipe
    import sobel_pkg::*;
#(
    parameter int DEPTH = SOBEL_PIPE_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  trk_t din,
    output trk_t tail
);
    trk_t [DEPTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        if (en) begin
            pipe_d[0] = din;
            for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pipe_q <= '0;
        else pipe_q <= pipe_d;
    end

    assign tail = pipe_q[DEPTH-1];
endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: raster sequencer and result tracker for the Sobel pipeline.
// Define SOBEL_CTRL_STATS_EN to add the input/output stall counters.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH    = IMG_WIDTH,
    parameter int HEIGHT   = IMG_HEIGHT,
    parameter int PIPE_LAT = SOBEL_PIPE_LAT,
    parameter int COL_W    = $clog2(WIDTH),
    parameter int ROW_W    = $clog2(HEIGHT)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic frame_done,
`ifdef SOBEL_CTRL_STATS_EN
    output logic [31:0] stall_in_cnt,
    output logic [31:0] stall_out_cnt,
`endif
    sobel_frame_ctrl_if.master bus
);
    localparam int TOTAL = (HEIGHT - 2) * WIDTH;
    localparam int OC_W  = $clog2(TOTAL + 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [OC_W-1:0]  OUT_TOTAL = OC_W'(TOTAL);

    ctrl_state_t      state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [OC_W-1:0]  out_cnt_q, out_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             feeding, stall, pipe_en, px_valid, out_wr_en, start_ok, row_end;
    trk_t             trk_in, tail;

    sobel_valid_pipe #(.DEPTH(PIPE_LAT)) u_valid_pipe (
        .clk  (clk),
        .rst  (rst),
        .en   (pipe_en),
        .din  (trk_in),
        .tail (tail)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        start_ok  = start && !busy;
        row_end   = px_valid && col_q == COL_LAST;
        out_cnt_d = start_ok ? '0 : out_cnt_q + OC_W'(out_wr_en);
        state_d   = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = start_ok ? FILL : state_q;
            FILL:       state_d = row_end && row_q == ROW_W'(1) ? RUN : FILL;
            RUN:        state_d = row_end && row_q == ROW_LAST ? DRAIN : RUN;
            DRAIN:      state_d = out_cnt_d == OUT_TOTAL ? DONE : DRAIN;
            default:    state_d = IDLE;
        endcase
        col_d        = start_ok ? '0 : px_valid ? (col_q == COL_LAST ? '0 : col_q + 1'b1) : col_q;
        row_d        = start_ok ? '0 : row_end && row_q != ROW_LAST ? row_q + 1'b1 : row_q;
        frame_done_d = state_q == DRAIN && state_d == DONE;
    end

    // A held tail result freezes the whole datapath, so nothing new may be popped.
    always_comb begin
        feeding       = state_q == FILL || state_q == RUN;
        busy          = feeding || state_q == DRAIN;
        stall         = tail.emit && bus.out_full;
        pipe_en       = busy && !stall;
        px_valid      = feeding && !bus.in_empty && pipe_en;
        out_wr_en     = tail.emit && !bus.out_full;
        trk_in.emit   = px_valid && row_q >= ROW_W'(2);
        trk_in.border = px_valid && (col_q < COL_W'(2) || col_q == COL_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_cnt_q    <= out_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done         = frame_done_q;
    assign bus.in_rd_en       = px_valid;
    assign bus.px_valid       = px_valid;
    assign bus.px_col         = col_q;
    assign bus.px_row         = row_q;
    assign bus.win_valid      = px_valid && row_q >= ROW_W'(2) && col_q >= COL_W'(2);
    assign bus.border         = trk_in.border;
    assign bus.pipe_en        = pipe_en;
    assign bus.out_wr_en      = out_wr_en;
    assign bus.out_force_zero = tail.border && tail.emit;

`ifdef SOBEL_CTRL_STATS_EN
    logic [31:0] stall_in_q, stall_in_d, stall_out_q, stall_out_d;

    always_comb begin
        stall_in_d  = start_ok ? '0 : stall_in_q + 32'(feeding && bus.in_empty && !(&stall_in_q));
        stall_out_d = start_ok ? '0 : stall_out_q + 32'(stall && !(&stall_out_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else begin
            stall_in_q  <= stall_in_d;
            stall_out_q <= stall_out_d;
        end
    end

    assign stall_in_cnt  = stall_in_q;
    assign stall_out_cnt = stall_out_q;
`endif
endmodule
